// File: rtl/freq_ctrl_pkg.sv
// Shared types and constants for the frequency auto-ranging controller.
// Gate-period table, threshold defaults and the controller state encoding.
package freq_ctrl_pkg;

  localparam int NUM_RANGES = 4;

  localparam int DEF_HI_THRESH = 100;
  localparam int DEF_LO_THRESH = 10;

  localparam int unsigned RANGE_PERIOD [NUM_RANGES] = '{
    4000, 1200, 400, 120
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DISCARD,
    MEASURE,
    EVAL
  } state_t;

endpackage

// File: rtl/freq_range_rom.sv
// Range index to gate period lookup, combinational.
// Also used by the display-scaling logic.
module freq_range_rom
  import freq_ctrl_pkg::*;
#(
  parameter int BITS = 12
) (
  input  logic [1:0]      range,
  output logic [BITS-1:0] period
);

  // Table read; longest window at index 0.
  always_comb begin
    period = BITS'(RANGE_PERIOD[range]);
  end

endmodule

// File: rtl/freq_autorange_ctrl.sv
// Auto-ranging gate controller: loads gate period, judges counts, steps range.
// Optional FREQ_AUTORANGE_HYST_EN: range change needs two same-direction strikes.
module freq_autorange_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int BITS       = 12,
  parameter int COUNT_W    = 7,
  parameter int HI_THRESH  = DEF_HI_THRESH,
  parameter int LO_THRESH  = DEF_LO_THRESH,
  parameter int INIT_RANGE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               meas_done,
  input  logic [COUNT_W-1:0] meas_count,
  output logic [BITS-1:0]    period,
  output logic               period_load,
  output logic [1:0]         range,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  output logic               overrange,
  output logic               underrange
);

  state_t state, nxt_state;

  logic [COUNT_W-1:0] cnt;
  logic hi, lo, up, dn, report;

`ifdef FREQ_AUTORANGE_HYST_EN
  logic hi_strike, lo_strike;
`endif

  // range only moves on the edge into LOAD, so period follows it there
  freq_range_rom #(.BITS(BITS)) u_rom (
    .range  (range),
    .period (period)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  // Judge the captured count and decide whether to step range.
  always_comb begin
    hi = cnt >= COUNT_W'(HI_THRESH);
    lo = cnt < COUNT_W'(LO_THRESH);
`ifdef FREQ_AUTORANGE_HYST_EN
    up = hi && (range != 2'd3) && hi_strike;
    dn = lo && (range != 2'd0) && lo_strike;
`else
    up = hi && (range != 2'd3);
    dn = lo && (range != 2'd0);
`endif
  end

  // Next-state logic; enable low always wins.
  always_comb begin
    nxt_state = state;
    if (!enable) begin
      nxt_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    nxt_state = LOAD;
        LOAD:    nxt_state = DISCARD;
        DISCARD: if (meas_done) nxt_state = MEASURE;
        MEASURE: if (meas_done) nxt_state = EVAL;
        EVAL:    nxt_state = (up || dn) ? LOAD : MEASURE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Moore strobe and report decision.
  always_comb begin
    period_load = (state == LOAD);
    report      = (state == EVAL) && enable && !up && !dn;
  end

  // Count capture, range stepping and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      range        <= 2'(INIT_RANGE);
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrange    <= 1'b0;
      underrange   <= 1'b0;
    end else begin
      result_valid <= report;
      if (state == MEASURE && meas_done && enable)
        cnt <= meas_count;
      if (state == EVAL && enable) begin
        if (up)      range <= range + 2'd1;
        else if (dn) range <= range - 2'd1;
      end
      if (report) begin
        result     <= cnt;
        overrange  <= hi;
        underrange <= lo;
      end
    end
  end

`ifdef FREQ_AUTORANGE_HYST_EN
  // First out-of-range window arms a strike; second one steps the range.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_strike <= 1'b0;
      lo_strike <= 1'b0;
    end else if (state == EVAL && enable) begin
      if (up || dn) begin
        hi_strike <= 1'b0;
        lo_strike <= 1'b0;
      end else begin
        hi_strike <= hi;
        lo_strike <= lo;
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_autorange_ctrl.sv
// Directed bench for freq_autorange_ctrl with immediate-assertion checks.
// Hysteresis scenario runs when FREQ_AUTORANGE_HYST_EN is defined.
module tb_freq_autorange_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        meas_done;
  logic [6:0]  meas_count;
  logic [11:0] period;
  logic        period_load;
  logic [1:0]  range;
  logic [6:0]  result;
  logic        result_valid;
  logic        overrange;
  logic        underrange;

  int pass_cnt = 0;
  int total    = 0;
  int exp_rng;
  int exp_per;

  freq_autorange_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .meas_done    (meas_done),
    .meas_count   (meas_count),
    .period       (period),
    .period_load  (period_load),
    .range        (range),
    .result       (result),
    .result_valid (result_valid),
    .overrange    (overrange),
    .underrange   (underrange)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // meas_done strobe at cycle n; returns at n+2 (report visible)
  task automatic pulse(input int c);
    meas_done  = 1'b1;
    meas_count = 7'(c);
    tick();
    meas_done  = 1'b0;
    meas_count = '0;
    tick();
  endtask

  task automatic report_chk(input string tag, input int res,
                            input int ov, input int un, input int rg);
    chk({tag, "_rv"},  int'(result_valid), 1);
    chk({tag, "_res"}, int'(result), res);
    chk({tag, "_ov"},  int'(overrange), ov);
    chk({tag, "_un"},  int'(underrange), un);
    chk({tag, "_pl"},  int'(period_load), 0);
    chk({tag, "_rng"}, int'(range), rg);
  endtask

  task automatic step_chk(input string tag, input int rg, input int per);
    chk({tag, "_rv"},  int'(result_valid), 0);
    chk({tag, "_pl"},  int'(period_load), 1);
    chk({tag, "_rng"}, int'(range), rg);
    chk({tag, "_per"}, int'(period), per);
    tick();
    pulse(50);
    chk({tag, "_disc_rv"}, int'(result_valid), 0);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    meas_done  = 1'b0;
    meas_count = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rng", int'(range), 1);
    chk("rst_per", int'(period), 1200);
    chk("rst_pl",  int'(period_load), 0);
    chk("rst_rv",  int'(result_valid), 0);
    chk("rst_res", int'(result), 0);
    chk("rst_ov",  int'(overrange), 0);
    chk("rst_un",  int'(underrange), 0);

    enable = 1'b1;
    tick();
    chk("en_pl",  int'(period_load), 1);
    chk("en_per", int'(period), 1200);
    chk("en_rng", int'(range), 1);
    tick();
    chk("en_pl_once", int'(period_load), 0);
    pulse(77);
    chk("first_disc_rv", int'(result_valid), 0);

    pulse(45);
    report_chk("s45a", 45, 0, 0, 1);
    tick();
    chk("s45_rv_1cyc", int'(result_valid), 0);
    pulse(45);
    report_chk("s45b", 45, 0, 0, 1);

`ifdef FREQ_AUTORANGE_HYST_EN
    pulse(127);
    report_chk("h1", 127, 1, 0, 1);
    pulse(30);
    report_chk("h2", 30, 0, 0, 1);
    pulse(127);
    report_chk("h3", 127, 1, 0, 1);
    pulse(127);
    step_chk("h4", 2, 400);
    exp_rng = 2;
    exp_per = 400;
`else
    pulse(120);
    chk("up_res_hold", int'(result), 45);
    step_chk("up12", 2, 400);
    pulse(40);
    report_chk("r2_40", 40, 0, 0, 2);

    pulse(3);
    step_chk("dn21", 1, 1200);
    pulse(3);
    step_chk("dn10", 0, 4000);
    pulse(5);
    report_chk("under", 5, 0, 1, 0);

    pulse(127);
    step_chk("up01", 1, 1200);
    pulse(127);
    step_chk("up12b", 2, 400);
    pulse(127);
    step_chk("up23", 3, 120);
    pulse(127);
    report_chk("over", 127, 1, 0, 3);
    pulse(50);
    report_chk("r3_50", 50, 0, 0, 3);
    exp_rng = 3;
    exp_per = 120;
`endif

    enable = 1'b0;
    tick();
    chk("dis_pl", int'(period_load), 0);
    chk("dis_rv", int'(result_valid), 0);
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
    chk("idle_md_rv", int'(result_valid), 0);
    enable = 1'b1;
    tick();
    chk("reen_pl",  int'(period_load), 1);
    chk("reen_per", int'(period), exp_per);
    chk("reen_rng", int'(range), exp_rng);
    tick();
    enable = 1'b0;
    tick();
    chk("disc_drop_pl", int'(period_load), 0);
    chk("disc_drop_rv", int'(result_valid), 0);
    chk("disc_drop_rng", int'(range), exp_rng);
    enable = 1'b1;
    tick();
    chk("reen2_pl",  int'(period_load), 1);
    chk("reen2_per", int'(period), exp_per);
    tick();
    pulse(50);

    reset      = 1'b1;
    meas_done  = 1'b1;
    meas_count = 7'd45;
    tick();
    reset      = 1'b0;
    meas_done  = 1'b0;
    chk("mrst_rng", int'(range), 1);
    chk("mrst_per", int'(period), 1200);
    chk("mrst_res", int'(result), 0);
    chk("mrst_rv",  int'(result_valid), 0);
    chk("mrst_ov",  int'(overrange), 0);
    chk("mrst_un",  int'(underrange), 0);
    chk("mrst_pl",  int'(period_load), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
